write_once_programmer: RTL and testbench

WRITE_ONCE_PROGRAMMER -- requirements
Module: write_once_programmer

---
 rtl/write_once_programmer.sv | 106 ++++++++++
 tb/tb_write_once_programmer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/write_once_programmer.sv
// write_once_programmer: programs a write-once register, optional readback verify/retry under WRITE_ONCE_READBACK_CHECK_EN
module write_once_programmer #(
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic                  Clk,
  input  logic                  ip_resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] Data_req,
  input  logic                  lock_req,
  input  logic [DATA_WIDTH-1:0] Reg_data_in,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] Status_out
);
`ifdef WRITE_ONCE_READBACK_CHECK_EN
  typedef enum logic [2:0] {IDLE, WRITE, SETTLE, READ, CHECK, DONE, ERROR} state_t;
  logic [2:0]            retry_q, retry_d;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic                  error_q, error_d;
  logic                  match;
  logic                  unused;
  assign unused = Data_req[0];
`else
  typedef enum logic [2:0] {IDLE, WRITE, SETTLE, DONE} state_t;
  logic unused;
  assign unused = ^{Data_req[0], Reg_data_in};
`endif
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic                  done_q, done_d;
  logic                  accept;
  assign accept = state_q == IDLE && start;
`ifdef WRITE_ONCE_READBACK_CHECK_EN
  assign match = status_q == data_q;
`endif
  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef WRITE_ONCE_READBACK_CHECK_EN
      retry_q  <= '0;
      status_q <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      write_q  <= write_d;
      done_q   <= done_d;
`ifdef WRITE_ONCE_READBACK_CHECK_EN
      retry_q  <= retry_d;
      status_q <= status_d;
      error_q  <= error_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = start ? WRITE : IDLE;
      WRITE:  state_d = SETTLE;
`ifdef WRITE_ONCE_READBACK_CHECK_EN
      SETTLE: state_d = cnt_q == 4'd0 ? READ : SETTLE;
      READ:   state_d = CHECK;
      CHECK:  state_d = match ? DONE : retry_q < 3'(MAX_RETRY) ? WRITE : ERROR;
`else
      SETTLE: state_d = cnt_q == 4'd0 ? DONE : SETTLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    data_d   = accept ? {Data_req[DATA_WIDTH-1:1], lock_req} : data_q;
    write_d  = state_d == WRITE;
    done_d   = state_d == DONE;
    cnt_d    = state_q == WRITE ? 4'(SETTLE_CYCLES - 1) : state_q == SETTLE ? cnt_q - 4'd1 : cnt_q;
`ifdef WRITE_ONCE_READBACK_CHECK_EN
    retry_d  = accept ? 3'd0 : state_q == CHECK && !match && retry_q < 3'(MAX_RETRY) ? retry_q + 3'd1 : retry_q;
    status_d = state_q == READ ? Reg_data_in : status_q;
    error_d  = state_d == ERROR ? 1'b1 : accept ? 1'b0 : error_q;
`endif
  end
  assign write    = write_q;
  assign Data_out = data_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
`ifdef WRITE_ONCE_READBACK_CHECK_EN
  assign error      = error_q;
  assign Status_out = status_q;
`else
  assign error      = 1'b0;
  assign Status_out = '0;
`endif
endmodule

// File: tb/tb_write_once_programmer.sv
// tb_write_once_programmer: randomized self-checking bench against a transaction-level model
module tb_write_once_programmer;
  localparam int DW = 16, S = 2, MR = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, lock_req = 1'b0;
  logic [DW-1:0] data_req = '0, reg_in = '0;
  logic write, busy, done, error;
  logic [DW-1:0] data_out, status_out;
  logic [DW-1:0] rb [MR+1];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  write_once_programmer #(.DATA_WIDTH(DW), .SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
    .Clk(clk), .ip_resetn(rst_n), .start(start), .Data_req(data_req), .lock_req(lock_req),
    .Reg_data_in(reg_in), .write(write), .Data_out(data_out), .busy(busy), .done(done),
    .error(error), .Status_out(status_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_write"}, 32'(write), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_error"}, 32'(error), 32'(0));
    chk({tag, "_dout"}, 32'(data_out), 32'(0));
    chk({tag, "_stat"}, 32'(status_out), 32'(0));
  endtask
  task automatic run(input logic [DW-1:0] req, input logic lk, input bit noise);
    logic [DW-1:0] v, exp_stat;
    logic exp_err, prev_w;
    int writes, done_cyc, err_cyc, exp_writes, exp_end, k, cyc, viol;
    v = {req[DW-1:1], lk};
`ifdef WRITE_ONCE_READBACK_CHECK_EN
    k = -1;
    for (int i = 0; i <= MR; i++) if (k < 0 && rb[i] == v) k = i;
    exp_err    = k < 0;
    exp_writes = exp_err ? MR + 1 : k + 1;
    exp_end    = S + 4 + (exp_writes - 1) * (S + 3);
    exp_stat   = rb[exp_writes-1];
`else
    k = 0;
    exp_err    = 1'b0;
    exp_writes = 1;
    exp_end    = S + 2;
    exp_stat   = '0;
`endif
    writes = 0; done_cyc = 0; err_cyc = 0; cyc = 0; viol = 0; prev_w = 1'b0;
    @(negedge clk);
    start = 1'b1; data_req = req; lock_req = lk; reg_in = 16'($urandom);
    while (cyc < 200 && done_cyc == 0 && err_cyc == 0) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk("write_c1", 32'(write), 32'(1));
        chk("err_clr_c1", 32'(error), 32'(0));
      end
      if (write) begin
        writes++;
        if (data_out !== v) viol++;
        reg_in = rb[(writes - 1 > MR) ? MR : writes - 1];
      end
      if (write && prev_w) viol++;
      if (done && error) viol++;
      if (!busy) viol++;
      prev_w = write;
      if (done) done_cyc = cyc;
      if (error && err_cyc == 0 && cyc > 1) err_cyc = cyc;
      start    = (noise && done_cyc == 0 && err_cyc == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_req = 16'($urandom);
      lock_req = 1'($urandom);
    end
    chk("end_cycle", 32'(exp_err ? err_cyc : done_cyc), 32'(exp_end));
    chk("other_flag", 32'(exp_err ? done_cyc : err_cyc), 32'(0));
    chk("writes", 32'(writes), 32'(exp_writes));
    chk("dout", 32'(data_out), 32'(v));
    chk("status", 32'(status_out), 32'(exp_stat));
    chk("violations", 32'(viol), 32'(0));
    @(posedge clk); #1;
    chk("post_busy", 32'(busy), 32'(0));
    chk("post_done", 32'(done), 32'(0));
    chk("post_error", 32'(error), 32'(exp_err));
  endtask
  task automatic reset_at(input int c);
    @(negedge clk);
    start = 1'b1; data_req = 16'h1234; lock_req = 1'b1;
    for (int i = 0; i < c; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_idle_zero($sformatf("rst_c%0d", c));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no_resume_busy", 32'(busy), 32'(0));
    end
  endtask
  initial begin
    for (int i = 0; i <= MR; i++) rb[i] = '0;
    #2;
    chk_idle_zero("reset");
    @(posedge clk); #1;
    chk_idle_zero("reset_edge");
    rst_n = 1'b1;
    for (int i = 0; i <= MR; i++) rb[i] = 16'hA5A5;
    run(16'hA5A4, 1'b1, 1'b0);
    for (int i = 0; i <= MR; i++) rb[i] = 16'h1235;
    run(16'hBEEE, 1'b0, 1'b0);
    rb[0] = 16'h0000;
    for (int i = 1; i <= MR; i++) rb[i] = 16'h00F1;
    run(16'h00F0, 1'b1, 1'b0);
    for (int i = 0; i <= MR; i++) rb[i] = 16'h5A5B;
    run(16'h5A5A, 1'b1, 1'b1);
    reset_at(2);
    for (int i = 0; i <= MR; i++) rb[i] = 16'hA5A5;
    run(16'hA5A4, 1'b1, 1'b0);
    reset_at(1);
    run(16'hA5A4, 1'b1, 1'b0);
    for (int t = 0; t < 40; t++) begin
      logic [DW-1:0] req, v;
      logic lk;
      req = 16'($urandom);
      lk  = 1'($urandom);
      v   = {req[DW-1:1], lk};
      for (int i = 0; i <= MR; i++) rb[i] = ($urandom_range(0, 2) == 0) ? v : 16'($urandom);
      run(req, lk, 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
